md_scheduler: RTL and testbench

- Sequencing controller for the pipeline's multiply/divide core; sits in E stage between the instruction stream and the combinational mult/div arithmetic core.
- Latches operands, issues a one-cycle start, models fixed latency (5 cycles mult, 10 cycles div) and owns the HI/LO architectural registers.
- Commits the core result to HI/LO at latency end and raises the D-stage stall for any MD-class instruction while an operation is in flight.

---
 rtl/md_scheduler_if.sv | 39 +++
 rtl/md_scheduler.sv | 134 +++++++++++++
 tb/tb_md_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/md_scheduler_if.sv
// Bus between the E-stage instruction stream, the multiply/divide scheduler and the
// combinational mult/div arithmetic core.
interface md_scheduler_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 3;

    logic              op_valid;
    logic [OP_W-1:0]   op_code;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              d_is_md;

    logic [DATA_W-1:0] core_a;
    logic [DATA_W-1:0] core_b;
    logic              core_signed;
    logic              core_is_div;
    logic [DATA_W-1:0] core_hi;
    logic [DATA_W-1:0] core_lo;

    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              start;
    logic              busy;
    logic              stall_md;

    // Pipeline plus arithmetic core side: drives instructions and core results.
    modport master (
        output op_valid, op_code, rs_val, rt_val, d_is_md, core_hi, core_lo,
        input  core_a, core_b, core_signed, core_is_div, hi_out, lo_out,
               start, busy, stall_md
    );

    // Scheduler side.
    modport slave (
        input  op_valid, op_code, rs_val, rt_val, d_is_md, core_hi, core_lo,
        output core_a, core_b, core_signed, core_is_div, hi_out, lo_out,
               start, busy, stall_md
    );
endinterface

// File: rtl/md_scheduler.sv
// Multiply/divide sequencing controller: latches operands, counts out the fixed core
// latency, owns HI/LO and requests D-stage stalls while an operation is in flight.
module md_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic          clk,
    input  logic          reset,
    md_scheduler_if.slave bus
);
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                signed_q, signed_d;
    logic                div_q, div_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                start_c;
    logic                div_by_zero_c;

    // State, countdown, operand latches and architectural HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            div_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            div_q    <= div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // A divide by zero runs its full latency but leaves HI/LO untouched.
    assign div_by_zero_c = div_q & (b_q == '0);

    // Next-state, operand capture, countdown and HI/LO write selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        div_d    = div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        start_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    case (bus.op_code)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            start_c  = 1'b1;
                            a_d      = bus.rs_val;
                            b_d      = bus.rt_val;
                            signed_d = (bus.op_code == OP_MULT) || (bus.op_code == OP_DIV);
                            div_d    = (bus.op_code == OP_DIV) || (bus.op_code == OP_DIVU);
                            cnt_d    = ((bus.op_code == OP_DIV) || (bus.op_code == OP_DIVU))
                                       ? DIV_LOAD : MULT_LOAD;
                            state_d  = RUN;
                        end
                        OP_MTHI: hi_d = bus.rs_val;
                        OP_MTLO: lo_d = bus.rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Instructions arriving here are stalled upstream and deliberately ignored.
                if (cnt_q == CNT_ONE) begin
                    if (!div_by_zero_c) begin
                        hi_d = bus.core_hi;
                        lo_d = bus.core_lo;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    assign bus.core_a      = a_q;
    assign bus.core_b      = b_q;
    assign bus.core_signed = signed_q;
    assign bus.core_is_div = div_q;
    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;
    assign bus.start       = start_c;
    assign bus.busy        = busy_q;
    assign bus.stall_md    = bus.d_is_md & (start_c | busy_q);

endmodule

// File: tb/tb_md_scheduler.sv
// Bench for md_scheduler: arithmetic-core stand-in, transaction-level HI/LO model,
// per-cycle comparison plus directed literal scenarios and a randomized phase.
module tb_md_scheduler;
    localparam int unsigned MULT_C = 5;
    localparam int unsigned DIV_C  = 10;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    md_scheduler_if bus ();

    md_scheduler #(
        .MULT_CYCLES (MULT_C),
        .DIV_CYCLES  (DIV_C),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic result as the real core would produce it; junk on divide by zero.
    function automatic logic [63:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic div);
        logic [63:0] ea, eb;
        int sa, sb;
        if (!div) begin
            ea = s ? {{32{a[31]}}, a} : {32'd0, a};
            eb = s ? {{32{b[31]}}, b} : {32'd0, b};
            return ea * eb;
        end
        if (b == 32'd0) return 64'hDEADBEEF_BAADF00D;
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        sa = int'(a);
        sb = int'(b);
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    always_comb {bus.core_hi, bus.core_lo} = core_fn(bus.core_a, bus.core_b,
                                                     bus.core_signed, bus.core_is_div);

    // Transaction-level model: remaining busy cycles plus captured operands.
    int          m_rem = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    logic        m_signed = 1'b0, m_div = 1'b0;
    logic [63:0] m_res;

    always_comb m_res = core_fn(m_a, m_b, m_signed, m_div);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem <= 0; m_hi <= '0; m_lo <= '0; m_a <= '0; m_b <= '0;
            m_signed <= 1'b0; m_div <= 1'b0;
        end else if (m_rem != 0) begin
            if (m_rem == 1 && !(m_div && m_b == 32'd0)) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
            m_rem <= m_rem - 1;
        end else if (bus.op_valid) begin
            if (bus.op_code <= 3'd3) begin
                m_a      <= bus.rs_val;
                m_b      <= bus.rt_val;
                m_signed <= (bus.op_code == 3'd0) || (bus.op_code == 3'd2);
                m_div    <= (bus.op_code == 3'd2) || (bus.op_code == 3'd3);
                m_rem    <= ((bus.op_code == 3'd2) || (bus.op_code == 3'd3)) ? DIV_C : MULT_C;
            end else if (bus.op_code == 3'd4) begin
                m_hi <= bus.rs_val;
            end else if (bus.op_code == 3'd5) begin
                m_lo <= bus.rs_val;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    logic exp_start, exp_busy;
    always @(negedge clk) begin
        exp_start = bus.op_valid && (bus.op_code <= 3'd3) && (m_rem == 0);
        exp_busy  = (m_rem != 0);
        check("start",       32'(bus.start),       32'(exp_start));
        check("busy",        32'(bus.busy),        32'(exp_busy));
        check("stall_md",    32'(bus.stall_md),    32'(bus.d_is_md && (exp_start || exp_busy)));
        check("hi_out",      bus.hi_out,           m_hi);
        check("lo_out",      bus.lo_out,           m_lo);
        check("core_a",      bus.core_a,           m_a);
        check("core_b",      bus.core_b,           m_b);
        check("core_signed", 32'(bus.core_signed), 32'(m_signed));
        check("core_is_div", 32'(bus.core_is_div), 32'(m_div));
    end

    // Issue one instruction with d_is_md held high and tally activity over n cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input int n, output int n_busy, output int n_stall,
                          output int n_start, output logic [31:0] mid_hi,
                          output logic [31:0] mid_lo);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        bus.rs_val   = rs;
        bus.rt_val   = rt;
        bus.d_is_md  = 1'b1;
        n_busy = 0; n_stall = 0; n_start = 0; mid_hi = '0; mid_lo = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_busy  += int'(bus.busy);
            n_stall += int'(bus.stall_md);
            n_start += int'(bus.start);
            if (i == 3) begin
                mid_hi = bus.hi_out;
                mid_lo = bus.lo_out;
            end
            @(posedge clk);
            #2;
            bus.op_valid = 1'b0;
        end
        bus.d_is_md = 1'b0;
    endtask

    int nb, ns, nst;
    logic [31:0] mh, ml;

    initial begin
        bus.op_valid = 1'b0;
        bus.op_code  = 3'd7;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        bus.d_is_md  = 1'b0;

        #1 reset = 1'b1;
        #2;
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_start", 32'(bus.start), 32'd0);
        check("rst_hi",    bus.hi_out,     32'd0);
        check("rst_lo",    bus.lo_out,     32'd0);
        check("rst_core_a", bus.core_a,    32'd0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;

        // MULT -2 * 3
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 8, nb, ns, nst, mh, ml);
        check("mult_busy_cycles",  32'(nb),  32'd5);
        check("mult_stall_cycles", 32'(ns),  32'd6);
        check("mult_start_cycles", 32'(nst), 32'd1);
        check("mult_hi", bus.hi_out, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo_out, 32'hFFFF_FFFA);

        // DIVU 100 / 7, HI/LO must hold the mult result while busy
        run_op(3'd3, 32'd100, 32'd7, 12, nb, ns, nst, mh, ml);
        check("divu_busy_cycles", 32'(nb), 32'd10);
        check("divu_mid_hi", mh, 32'hFFFF_FFFF);
        check("divu_mid_lo", ml, 32'hFFFF_FFFA);
        check("divu_hi", bus.hi_out, 32'd2);
        check("divu_lo", bus.lo_out, 32'd14);

        // MTHI / MTLO
        run_op(3'd4, 32'h1234_5678, 32'd0, 1, nb, ns, nst, mh, ml);
        check("mthi_busy",  32'(nb), 32'd0);
        check("mthi_stall", 32'(ns), 32'd0);
        check("mthi_hi", bus.hi_out, 32'h1234_5678);
        run_op(3'd5, 32'h9ABC_DEF0, 32'd0, 1, nb, ns, nst, mh, ml);
        check("mtlo_stall", 32'(ns), 32'd0);
        check("mtlo_lo", bus.lo_out, 32'h9ABC_DEF0);
        check("mtlo_hi_kept", bus.hi_out, 32'h1234_5678);

        // DIV by zero keeps HI/LO
        run_op(3'd4, 32'h11, 32'd0, 1, nb, ns, nst, mh, ml);
        run_op(3'd5, 32'h22, 32'd0, 1, nb, ns, nst, mh, ml);
        run_op(3'd2, 32'd5, 32'd0, 12, nb, ns, nst, mh, ml);
        check("div0_busy_cycles", 32'(nb), 32'd10);
        check("div0_hi", bus.hi_out, 32'h11);
        check("div0_lo", bus.lo_out, 32'h22);

        // Asynchronous reset in the third busy cycle of a MULT
        run_op(3'd0, 32'd3, 32'd4, 1, nb, ns, nst, mh, ml);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_hi", bus.hi_out, 32'd0);
        check("arst_lo", bus.lo_out, 32'd0);
        check("arst_core_a", bus.core_a, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
        end
        check("arst_no_commit_hi", bus.hi_out, 32'd0);
        check("arst_no_commit_lo", bus.lo_out, 32'd0);
        check("arst_idle_busy", 32'(bus.busy), 32'd0);

        // MTHI presented during RUN must be ignored
        run_op(3'd1, 32'h0001_0000, 32'h0003_0000, 1, nb, ns, nst, mh, ml);
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd4;
        bus.rs_val   = 32'h0000_DEAD;
        @(posedge clk); #2;
        bus.op_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
        end
        check("ign_hi", bus.hi_out, 32'd3);
        check("ign_lo", bus.lo_out, 32'd0);
        check("ign_core_a", bus.core_a, 32'h0001_0000);

        // Randomized traffic, including protocol violations and stray resets
        for (int i = 0; i < 600; i++) begin
            bus.op_valid = 1'($urandom_range(0, 1));
            bus.op_code  = 3'($urandom_range(0, 7));
            bus.rs_val   = $urandom;
            if ($urandom_range(0, 5) == 0)      bus.rt_val = 32'd0;
            else if ($urandom_range(0, 1) == 1) bus.rt_val = $urandom;
            else                                bus.rt_val = 32'($urandom_range(1, 20));
            bus.d_is_md  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 149) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            @(posedge clk); #2;
        end

        bus.op_valid = 1'b0;
        bus.d_is_md  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #2;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
